// File: rtl/pdu_pchmask_seq.sv
// Translates a logical-qubit mask into a physical-patch mask by walking the patch map table once per lq.
// Optional build macro PDU_PCHCONFLICT_CHK_EN adds the sticky patch-collision detector.
module pdu_pchmask_seq #(
  parameter int unsigned NUM_LQ     = 6,
  parameter int unsigned NUM_PCH    = 12,
  parameter int unsigned LQADDR_BW  = 3,
  parameter int unsigned PCHADDR_BW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_LQ-1:0]     lq_mask,
  output logic                  busy,
  output logic [LQADDR_BW-1:0]  lqidx,
  input  logic [PCHADDR_BW-1:0] rd_pchidx0,
  input  logic [PCHADDR_BW-1:0] rd_pchidx1,
  output logic [NUM_PCH-1:0]    pch_mask,
  output logic                  pch_valid,
  input  logic                  pch_ack,
  output logic                  conflict,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [LQADDR_BW-1:0]  cnt_q, cnt_d;
  logic [NUM_LQ-1:0]     lqm_q, lqm_d;
  logic [NUM_PCH-1:0]    acc_q, acc_d;
  logic [NUM_PCH-1:0]    hit_bits;
  logic                  sel;
  logic                  last_idx;

  // Patch indices outside the patch range contribute nothing.
  always_comb begin
    hit_bits = '0;
    if (32'(rd_pchidx0) < NUM_PCH) hit_bits[rd_pchidx0] = 1'b1;
    if (32'(rd_pchidx1) < NUM_PCH) hit_bits[rd_pchidx1] = 1'b1;
  end

  assign sel      = lqm_q[cnt_q];
  assign last_idx = (cnt_q == LQADDR_BW'(NUM_LQ - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lqm_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lqm_q   <= lqm_d;
      acc_q   <= acc_d;
    end
  end

  // Handshake: pch_valid stays high with pch_mask frozen until the cycle pch_ack is sampled high;
  // pch_ack is meaningful only while pch_valid is high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lqm_d     = lqm_q;
    acc_d     = acc_q;
    busy      = (state_q != IDLE);
    pch_valid = (state_q == HOLD);
    lqidx     = '0;
    pch_mask  = acc_q;
    dbg_state = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          lqm_d   = lq_mask;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        lqidx = cnt_q;
        if (sel) acc_d = acc_q | hit_bits;
        if (last_idx) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (pch_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PDU_PCHCONFLICT_CHK_EN
  logic conf_q;

  // Only bits left by earlier lqs count; both indices of the same lq hitting one patch is legal.
  always_ff @(posedge clk) begin
    if (rst) begin
      conf_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      conf_q <= 1'b0;
    end else if (state_q == SCAN && sel && |(hit_bits & acc_q)) begin
      conf_q <= 1'b1;
    end
  end

  assign conflict = conf_q;
`else
  assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_pdu_pchmask_seq.sv
// Directed bench for pdu_pchmask_seq: vector table of masks/stub maps plus hand sequences for
// ignored start/ack, long hold, and reset aborts.
module tb_pdu_pchmask_seq;

  localparam int NUM_LQ = 6;
  localparam int NUM_PCH = 12;

`ifdef PDU_PCHCONFLICT_CHK_EN
  localparam logic CONF_EXP = 1'b1;
`else
  localparam logic CONF_EXP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic [5:0]        lq_mask;
  logic              busy;
  logic [2:0]        lqidx;
  logic [3:0]        rd_pchidx0;
  logic [3:0]        rd_pchidx1;
  logic [11:0]       pch_mask;
  logic              pch_valid;
  logic              pch_ack;
  logic              conflict;
  logic [1:0]        dbg_state;
  int                stub_mode;
  int                n_chk;
  int                n_fail;

  typedef struct {
    logic [5:0]  lq_mask;
    int          mode;
    logic [11:0] exp_mask;
    logic        exp_conf;
  } vec_t;

  vec_t vecs[7];

  pdu_pchmask_seq #(
    .NUM_LQ(6), .NUM_PCH(12), .LQADDR_BW(3), .PCHADDR_BW(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .lq_mask(lq_mask), .busy(busy), .lqidx(lqidx),
    .rd_pchidx0(rd_pchidx0), .rd_pchidx1(rd_pchidx1), .pch_mask(pch_mask),
    .pch_valid(pch_valid), .pch_ack(pch_ack), .conflict(conflict), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Patch map stub: mode 0 normal, mode 1 lq2/lq4 both map to patch 3, mode 2 lq0 out of range.
  always_comb begin
    rd_pchidx0 = 4'd0;
    rd_pchidx1 = 4'd0;
    case (lqidx)
      3'd0: begin rd_pchidx0 = 4'd0;  rd_pchidx1 = 4'd4;  end
      3'd1: begin rd_pchidx0 = 4'd1;  rd_pchidx1 = 4'd5;  end
      3'd2: begin rd_pchidx0 = 4'd2;  rd_pchidx1 = 4'd2;  end
      3'd3: begin rd_pchidx0 = 4'd10; rd_pchidx1 = 4'd10; end
      3'd4: begin rd_pchidx0 = 4'd3;  rd_pchidx1 = 4'd3;  end
      3'd5: begin rd_pchidx0 = 4'd7;  rd_pchidx1 = 4'd7;  end
      default: ;
    endcase
    if (stub_mode == 1 && (lqidx == 3'd2 || lqidx == 3'd4)) begin
      rd_pchidx0 = 4'd3;
      rd_pchidx1 = 4'd3;
    end
    if (stub_mode == 2 && lqidx == 3'd0) begin
      rd_pchidx0 = 4'd12;
      rd_pchidx1 = 4'd15;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start an operation at cycle 0 and follow it into HOLD; valid must rise exactly at cycle 7.
  task automatic start_and_wait(input logic [5:0] m, input int mode, input logic [11:0] exp_mask,
                                input logic exp_conf, input string tag);
    bit got;
    got = 1'b0;
    stub_mode = mode;
    lq_mask = m;
    start = 1'b1;
    for (int c = 1; c <= 20 && !got; c++) begin
      step();
      start = 1'b0;
      if (c == 1) begin
        chk({tag, " busy_c1"}, 32'(busy), 32'd1);
        chk({tag, " conf_cleared"}, 32'(conflict), 32'd0);
      end
      if (c <= NUM_LQ) chk($sformatf("%s lqidx_c%0d", tag, c), 32'(lqidx), 32'(c - 1));
      if (pch_valid) begin
        got = 1'b1;
        chk({tag, " valid_cycle"}, 32'(c), 32'(NUM_LQ + 1));
      end
    end
    if (!got) chk({tag, " valid_timeout"}, 32'd0, 32'd1);
    chk({tag, " pch_mask"}, 32'(pch_mask), 32'(exp_mask));
    chk({tag, " conflict"}, 32'(conflict), 32'(exp_conf));
    chk({tag, " lqidx_hold"}, 32'(lqidx), 32'd0);
  endtask

  task automatic ack_and_check(input logic [11:0] exp_mask, input logic exp_conf, input string tag);
    pch_ack = 1'b1;
    step();
    pch_ack = 1'b0;
    chk({tag, " busy_after_ack"}, 32'(busy), 32'd0);
    chk({tag, " valid_after_ack"}, 32'(pch_valid), 32'd0);
    chk({tag, " mask_retained"}, 32'(pch_mask), 32'(exp_mask));
    chk({tag, " conf_sticky"}, 32'(conflict), 32'(exp_conf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    stub_mode = 0;
    vecs[0] = '{6'b000011, 0, 12'h033, 1'b0};
    vecs[1] = '{6'b111111, 0, 12'h4BF, 1'b0};
    vecs[2] = '{6'b000000, 0, 12'h000, 1'b0};
    vecs[3] = '{6'b010100, 1, 12'h008, CONF_EXP};
    vecs[4] = '{6'b000011, 2, 12'h022, 1'b0};
    vecs[5] = '{6'b100100, 0, 12'h084, 1'b0};
    vecs[6] = '{6'b000100, 1, 12'h008, 1'b0};

    // reset overrides start and ack
    rst = 1'b1;
    start = 1'b1;
    pch_ack = 1'b1;
    lq_mask = 6'h3F;
    step();
    step();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst valid", 32'(pch_valid), 32'd0);
    chk("rst mask", 32'(pch_mask), 32'd0);
    chk("rst lqidx", 32'(lqidx), 32'd0);
    chk("rst conflict", 32'(conflict), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    step();
    // ack in IDLE is a no-op
    chk("idle ack ignored", 32'(busy), 32'd0);
    pch_ack = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      start_and_wait(vecs[i].lq_mask, vecs[i].mode, vecs[i].exp_mask, vecs[i].exp_conf,
                     $sformatf("vec%0d", i));
      ack_and_check(vecs[i].exp_mask, vecs[i].exp_conf, $sformatf("vec%0d", i));
      step();
    end

    // start and ack during SCAN ignored, long HOLD, start ignored in HOLD and in ack cycle
    stub_mode = 0;
    lq_mask = 6'h3F;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    pch_ack = 1'b1;
    step();
    pch_ack = 1'b0;
    start = 1'b1;
    lq_mask = 6'h01;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("seqA valid_c7", 32'(pch_valid), 32'd1);
    chk("seqA mask_c7", 32'(pch_mask), 32'h4BF);
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      lq_mask = 6'h00;
      step();
      chk($sformatf("seqA hold_valid%0d", i), 32'(pch_valid), 32'd1);
      chk($sformatf("seqA hold_mask%0d", i), 32'(pch_mask), 32'h4BF);
    end
    start = 1'b0;
    pch_ack = 1'b1;
    start = 1'b1;
    step();
    pch_ack = 1'b0;
    start = 1'b0;
    chk("seqA busy_after_ack", 32'(busy), 32'd0);
    chk("seqA mask_after_ack", 32'(pch_mask), 32'h4BF);
    step();
    chk("seqA still_idle", 32'(busy), 32'd0);

    // reset while lqidx==3 aborts with no valid pulse
    lq_mask = 6'h3F;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("seqB lqidx_before_rst", 32'(lqidx), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("seqB busy", 32'(busy), 32'd0);
    chk("seqB mask", 32'(pch_mask), 32'd0);
    chk("seqB lqidx", 32'(lqidx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("seqB no_valid%0d", i), 32'(pch_valid), 32'd0);
    end

    // reset in HOLD, then start in the first cycle after reset releases
    start_and_wait(6'b000011, 0, 12'h033, 1'b0, "seqC");
    rst = 1'b1;
    step();
    chk("seqC valid_after_rst", 32'(pch_valid), 32'd0);
    chk("seqC mask_after_rst", 32'(pch_mask), 32'd0);
    rst = 1'b0;
    start_and_wait(6'b111111, 0, 12'h4BF, 1'b0, "seqD");
    ack_and_check(12'h4BF, 1'b0, "seqD");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
